// File: rtl/debouncer_multi.sv
// debouncer_multi: N-channel push-button debouncer with per-channel one-hot mode.
// Each channel: 2-FF synchroniser, stability counter, debounced level,
// registered press/release pulses and a one-hot mode register rotated on press.
// Optional feature macro: DEBOUNCER_LONG_PRESS_EN (hold counter, long_press pulse,
// mode forced back to bit 0 when a hold reaches LONG_CYCLES).
// The release pulse port is named release_pulse because "release" is a reserved
// word in SystemVerilog.
module debouncer_multi #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 10000,
    parameter int MODES         = 4,
    parameter int ACTIVE_LOW    = 0,
    parameter int LONG_CYCLES   = 100000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       button,
    output logic [CHANNELS-1:0]       level,
    output logic [CHANNELS-1:0]       press,
    output logic [CHANNELS-1:0]       release_pulse,
    output logic [CHANNELS*MODES-1:0] out_mode,
    output logic [CHANNELS-1:0]       long_press
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [MODES-1:0] MODE_INIT = {{(MODES-1){1'b0}}, 1'b1};

    // Rotate a one-hot mode vector left by one, top bit wrapping to bit 0.
    function automatic logic [MODES-1:0] rotate_mode(input logic [MODES-1:0] m);
        return {m[MODES-2:0], m[MODES-1]};
    endfunction

    logic [CHANNELS-1:0] in_s;

    // Map pin polarity so that 1 always means "pressed" downstream.
    always_comb begin
        if (ACTIVE_LOW != 0) begin
            in_s = ~button;
        end else begin
            in_s = button;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : ch_g
        logic             s1_r;
        logic             s2_r;
        logic             level_r;
        logic             press_r;
        logic             rel_r;
        logic [CW-1:0]    cnt_r;
        logic [MODES-1:0] mode_r;
        logic             flip_s;
        logic             long_hit_s;
        logic [CW-1:0]    cnt_nxt_s;
        logic [MODES-1:0] mode_nxt_s;

`ifdef DEBOUNCER_LONG_PRESS_EN
        localparam int HW = $clog2(LONG_CYCLES + 1);
        localparam logic [HW-1:0] HOLD_ZERO = HW'(0);
        localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
        localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
        localparam logic [HW-1:0] HOLD_HIT  = HW'(LONG_CYCLES - 1);

        logic [HW-1:0] hold_r;
        logic          long_r;

        // The hold counter saturates, so the hit value is seen only once per hold.
        always_comb begin
            long_hit_s = level_r & (hold_r == HOLD_HIT);
        end

        // Hold counter and long_press pulse: count while debounced high, clear when low.
        always_ff @(posedge clk) begin
            if (reset) begin
                hold_r <= HOLD_ZERO;
                long_r <= 1'b0;
            end else begin
                long_r <= long_hit_s;
                if (!level_r) begin
                    hold_r <= HOLD_ZERO;
                end else if (hold_r != HOLD_MAX) begin
                    hold_r <= hold_r + HOLD_ONE;
                end else begin
                    hold_r <= hold_r;
                end
            end
        end

        assign long_press[c] = long_r;
`else
        // Without the hold feature there is never a long-press event.
        always_comb begin
            long_hit_s = 1'b0;
        end

        // LONG_CYCLES has no effect in this build; the output is a constant 0.
        assign long_press[c] = (LONG_CYCLES < 0) ? 1'b1 : 1'b0;
`endif

        // Stability counter and mode next-state: flip only after a full stable run.
        always_comb begin
            flip_s     = 1'b0;
            cnt_nxt_s  = cnt_r;
            mode_nxt_s = mode_r;
            if (s2_r == level_r) begin
                cnt_nxt_s = CNT_ZERO;
            end else if (cnt_r == CNT_LAST) begin
                flip_s    = 1'b1;
                cnt_nxt_s = CNT_ZERO;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
            if (long_hit_s) begin
                mode_nxt_s = MODE_INIT;
            end else if (flip_s && s2_r) begin
                mode_nxt_s = rotate_mode(mode_r);
            end else begin
                mode_nxt_s = mode_r;
            end
        end

        // Synchroniser, debounced level, edge pulses and mode register.
        always_ff @(posedge clk) begin
            if (reset) begin
                s1_r    <= 1'b0;
                s2_r    <= 1'b0;
                level_r <= 1'b0;
                press_r <= 1'b0;
                rel_r   <= 1'b0;
                cnt_r   <= CNT_ZERO;
                mode_r  <= MODE_INIT;
            end else begin
                s1_r    <= in_s[c];
                s2_r    <= s1_r;
                cnt_r   <= cnt_nxt_s;
                press_r <= flip_s & s2_r;
                rel_r   <= flip_s & ~s2_r;
                mode_r  <= mode_nxt_s;
                if (flip_s) begin
                    level_r <= s2_r;
                end else begin
                    level_r <= level_r;
                end
            end
        end

        assign level[c]                  = level_r;
        assign press[c]                  = press_r;
        assign release_pulse[c]          = rel_r;
        assign out_mode[c*MODES +: MODES] = mode_r;
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// Self-checking bench for debouncer_multi (CHANNELS=2, STABLE_CYCLES=8, MODES=4,
// LONG_CYCLES=32). Expected outputs are pushed to a scoreboard queue, keyed by the
// edge number at which they must appear, and compared every cycle #1 after posedge.
module tb_debouncer_multi;

    localparam int CH   = 2;
    localparam int ST   = 8;
    localparam int MD   = 4;
    localparam int LONG = 32;
    localparam int LAT  = ST + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] button;
    logic [CH-1:0] level;
    logic [CH-1:0] press;
    logic [CH-1:0] release_pulse;
    logic [CH*MD-1:0] out_mode;
    logic [CH-1:0] long_press;

    debouncer_multi #(
        .CHANNELS(CH), .STABLE_CYCLES(ST), .MODES(MD), .ACTIVE_LOW(0), .LONG_CYCLES(LONG)
    ) dut (
        .clk(clk), .reset(reset), .button(button), .level(level), .press(press),
        .release_pulse(release_pulse), .out_mode(out_mode), .long_press(long_press)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rls;
        logic [7:0] mode;
        logic [1:0] lp;
    } exp_t;

    typedef struct {
        logic [1:0] mask;
        logic [7:0] mode;
    } vec_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [7:0] exp_mode;

    task automatic compare(input string name, input exp_t e);
        n_cmp++;
        if (level !== e.lvl || press !== e.prs || release_pulse !== e.rls ||
            out_mode !== e.mode || long_press !== e.lp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got lvl=%b prs=%b rls=%b mode=%h lp=%b need lvl=%b prs=%b rls=%b mode=%h lp=%b",
                     name, cyc, level, press, release_pulse, out_mode, long_press,
                     e.lvl, e.prs, e.rls, e.mode, e.lp);
        end
    endtask

    task automatic tick(input string name);
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s stale expectation cyc=%0d now=%0d", name, e.cyc, cyc);
            end else begin
                compare(name, e);
            end
        end
    endtask

    task automatic check_now(input string name, input logic [1:0] lvl, input logic [7:0] mode);
        exp_t e;
        e.cyc = cyc; e.lvl = lvl; e.prs = 2'b00; e.rls = 2'b00; e.mode = mode; e.lp = 2'b00;
        compare(name, e);
    endtask

    // Press channels in mask for hi edges, then release for lo edges (lo >= LAT).
    task automatic pulse(input string name, input logic [1:0] mask, input int hi, input int lo,
                         input logic [7:0] m_before, input logic [7:0] m_after,
                         input logic [7:0] m_long);
        exp_t e;
        for (int k = 1; k <= hi + lo; k++) begin
            e.cyc  = cyc + k;
            e.lvl  = (k >= LAT && k < hi + LAT) ? mask : 2'b00;
            e.prs  = (k == LAT) ? mask : 2'b00;
            e.rls  = (k == hi + LAT) ? mask : 2'b00;
            e.mode = (k < LAT) ? m_before : m_after;
            e.lp   = 2'b00;
`ifdef DEBOUNCER_LONG_PRESS_EN
            if (hi > LONG && k >= LAT + LONG) begin
                e.mode = m_long;
                e.lp   = (k == LAT + LONG) ? mask : 2'b00;
            end
`endif
            sb.push_back(e);
        end
        button = mask;
        for (int k = 1; k <= hi + lo; k++) begin
            tick(name);
            if (k == hi) button = 2'b00;
        end
    endtask

    task automatic do_reset(input int n);
        reset  = 1'b1;
        button = 2'b00;
        repeat (n) tick("reset");
        reset  = 1'b0;
        check_now("reset_state", 2'b00, 8'h11);
        exp_mode = 8'h11;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        exp_t e;
        logic [7:0] m_hold;
        tbl[0] = '{2'b10, 8'h24};
        tbl[1] = '{2'b10, 8'h44};
        tbl[2] = '{2'b10, 8'h84};
        tbl[3] = '{2'b10, 8'h14};
        tbl[4] = '{2'b11, 8'h28};

        reset  = 1'b1;
        button = 2'b00;

        // 1: reset
        do_reset(5);

        // 2: ch0 clean press/release
        pulse("single_press", 2'b01, 20, 12, exp_mode, 8'h12, 8'h12);
        exp_mode = 8'h12;

        // 3: bounce high4/low4 x3 must produce nothing, then clean press
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 8; k++) begin
                button = (k < 4) ? 2'b01 : 2'b00;
                e.cyc = cyc + 1; e.lvl = 2'b00; e.prs = 2'b00; e.rls = 2'b00;
                e.mode = exp_mode; e.lp = 2'b00;
                sb.push_back(e);
                tick("bounce");
            end
        end
        pulse("after_bounce", 2'b01, 12, 12, exp_mode, 8'h14, 8'h14);
        exp_mode = 8'h14;

        // 4: table of presses: ch1 wrap, then simultaneous
        for (int i = 0; i < 5; i++) begin
            pulse("mode_table", tbl[i].mask, 12, 12, exp_mode, tbl[i].mode, tbl[i].mode);
            exp_mode = tbl[i].mode;
        end

        // 5: long hold on ch0 from mode 0100
        do_reset(2);
        pulse("pre_long_a", 2'b01, 12, 12, 8'h11, 8'h12, 8'h12);
        pulse("pre_long_b", 2'b01, 12, 12, 8'h12, 8'h14, 8'h14);
        pulse("long_hold", 2'b01, 60, 12, 8'h14, 8'h18, 8'h11);
`ifdef DEBOUNCER_LONG_PRESS_EN
        m_hold = 8'h11;
`else
        m_hold = 8'h18;
`endif
        check_now("after_long", 2'b00, m_hold);

        // 6: reset while ch0 held, then press after full debounce post-reset
        do_reset(2);
        button = 2'b01;
        for (int k = 1; k <= 14; k++) begin
            e.cyc = cyc + k;
            e.lvl = (k >= LAT) ? 2'b01 : 2'b00;
            e.prs = (k == LAT) ? 2'b01 : 2'b00;
            e.rls = 2'b00;
            e.mode = (k < LAT) ? 8'h11 : 8'h12;
            e.lp = 2'b00;
            sb.push_back(e);
        end
        for (int k = 1; k <= 14; k++) tick("pre_reset_hold");
        reset = 1'b1;
        tick("mid_reset");
        reset = 1'b0;
        check_now("mid_reset_state", 2'b00, 8'h11);
        for (int k = 1; k <= 12; k++) begin
            e.cyc = cyc + k;
            e.lvl = (k >= LAT) ? 2'b01 : 2'b00;
            e.prs = (k == LAT) ? 2'b01 : 2'b00;
            e.rls = 2'b00;
            e.mode = (k < LAT) ? 8'h11 : 8'h12;
            e.lp = 2'b00;
            sb.push_back(e);
        end
        for (int k = 1; k <= 12; k++) tick("post_reset");

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain left=%0d need=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
